// File: rtl/sound_event_pkg.sv
// Shared types and sizing helper for the game-to-audio sound event producer.
// Optional auto-repeat is enabled with SOUND_EVENT_GEN_REPEAT_EN.
package sound_event_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_JUMP = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_FWD   = 2'd0,
        DIR_BACK  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // One spare bit above the largest hold so a loaded count can never wrap.
    function automatic int hold_width(input int jump_h, input int win_h, input int lose_h);
        int max_h;
        max_h = jump_h;
        if (win_h > max_h) max_h = win_h;
        if (lose_h > max_h) max_h = lose_h;
        return $clog2(max_h) + 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw button, emitting a one-cycle press pulse.
// With SOUND_EVENT_GEN_REPEAT_EN defined, a held button re-issues presses periodically.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef SOUND_EVENT_GEN_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 12500000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    import sound_event_pkg::*;

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1_q, sync2_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          press_q, press_d;

`ifdef SOUND_EVENT_GEN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    logic [RW-1:0] rep_q, rep_d;
`endif

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = deb_d & ~deb_q;
`ifdef SOUND_EVENT_GEN_REPEAT_EN
        // Timer is phase-locked to the original press and reloads on each repeat.
        rep_d = rep_q;
        if (deb_d & ~deb_q) begin
            rep_d = RW'(REPEAT_CYCLES);
        end else if (deb_q & deb_d) begin
            if (rep_q == RW'(1)) begin
                press_d = 1'b1;
                rep_d   = RW'(REPEAT_CYCLES);
            end else begin
                rep_d = rep_q - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
`ifdef SOUND_EVENT_GEN_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
`ifdef SOUND_EVENT_GEN_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign press = press_q;

endmodule

// File: rtl/sound_event_gen.sv
// Turns debounced direction presses and win/lose pulses into mutually exclusive held sound requests.
// Optional auto-repeat of held buttons is enabled with SOUND_EVENT_GEN_REPEAT_EN.
module sound_event_gen #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int JUMP_HOLD_CYCLES = 2500000,
    parameter int WIN_HOLD_CYCLES  = 25000000,
    parameter int LOSE_HOLD_CYCLES = 25000000,
    parameter int REPEAT_CYCLES    = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btnUp,
    input  logic btnDown,
    input  logic btnLeft,
    input  logic btnRight,
    input  logic winPulse,
    input  logic losePulse,
    output logic jumpForward,
    output logic jumpBackward,
    output logic jumpLeft,
    output logic jumpRight,
    output logic win,
    output logic lose
);
    import sound_event_pkg::*;

    localparam int HW = hold_width(JUMP_HOLD_CYCLES, WIN_HOLD_CYCLES, LOSE_HOLD_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || JUMP_HOLD_CYCLES < 1 || WIN_HOLD_CYCLES < 1 ||
        LOSE_HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("sound_event_gen: all cycle parameters must be at least 1");
    end

    logic [3:0] btn_raw;
    logic [3:0] press;

    assign btn_raw = {btnRight, btnLeft, btnDown, btnUp};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef SOUND_EVENT_GEN_REPEAT_EN
            ,
            .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_raw[i]),
            .press(press[i])
        );
    end

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d, dir_sel;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [5:0]    out_q, out_d;

    always_comb begin
        if (press[0])      dir_sel = DIR_FWD;
        else if (press[1]) dir_sel = DIR_BACK;
        else if (press[2]) dir_sel = DIR_LEFT;
        else               dir_sel = DIR_RIGHT;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        if (winPulse) begin
            state_d = S_WIN;
            cnt_d   = HW'(WIN_HOLD_CYCLES);
        end else if (losePulse) begin
            state_d = S_LOSE;
            cnt_d   = HW'(LOSE_HOLD_CYCLES);
        end else if ((|press) && (state_q == S_IDLE || state_q == S_JUMP)) begin
            state_d = S_JUMP;
            dir_d   = dir_sel;
            cnt_d   = HW'(JUMP_HOLD_CYCLES);
        end else if (state_q != S_IDLE) begin
            if (cnt_q == HW'(1)) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Outputs are decoded from next state so they change on the same edge as the FSM.
    always_comb begin
        out_d    = '0;
        out_d[5] = (state_d == S_JUMP) && (dir_d == DIR_FWD);
        out_d[4] = (state_d == S_JUMP) && (dir_d == DIR_BACK);
        out_d[3] = (state_d == S_JUMP) && (dir_d == DIR_LEFT);
        out_d[2] = (state_d == S_JUMP) && (dir_d == DIR_RIGHT);
        out_d[1] = (state_d == S_WIN);
        out_d[0] = (state_d == S_LOSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_FWD;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign jumpForward  = out_q[5];
    assign jumpBackward = out_q[4];
    assign jumpLeft     = out_q[3];
    assign jumpRight    = out_q[2];
    assign win          = out_q[1];
    assign lose         = out_q[0];

endmodule

// File: tb/tb_sound_event_gen.sv
// Directed bench for sound_event_gen with short debounce/hold parameters.
module tb_sound_event_gen;

    localparam int DB = 4;
    localparam int JH = 8;
    localparam int WH = 16;
    localparam int LH = 12;
    localparam int RP = 20;

    localparam logic [5:0] O_FWD  = 6'b100000;
    localparam logic [5:0] O_BACK = 6'b010000;
    localparam logic [5:0] O_LEFT = 6'b001000;
    localparam logic [5:0] O_RGHT = 6'b000100;
    localparam logic [5:0] O_WIN  = 6'b000010;
    localparam logic [5:0] O_LOSE = 6'b000001;

`ifdef SOUND_EVENT_GEN_REPEAT_EN
    localparam int HELD_BACK_RISES = 3;
`else
    localparam int HELD_BACK_RISES = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
    logic winPulse = 1'b0, losePulse = 1'b0;
    logic jumpForward, jumpBackward, jumpLeft, jumpRight, win, lose;
    logic [5:0] outs;

    int checks = 0;
    int errors = 0;
    int rises[6] = '{default: 0};
    int multi = 0;
    logic [5:0] prev = '0;
    int base;

    always #5 clk = ~clk;

    sound_event_gen #(
        .DEBOUNCE_CYCLES (DB),
        .JUMP_HOLD_CYCLES(JH),
        .WIN_HOLD_CYCLES (WH),
        .LOSE_HOLD_CYCLES(LH),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btnUp       (btnUp),
        .btnDown     (btnDown),
        .btnLeft     (btnLeft),
        .btnRight    (btnRight),
        .winPulse    (winPulse),
        .losePulse   (losePulse),
        .jumpForward (jumpForward),
        .jumpBackward(jumpBackward),
        .jumpLeft    (jumpLeft),
        .jumpRight   (jumpRight),
        .win         (win),
        .lose        (lose)
    );

    assign outs = {jumpForward, jumpBackward, jumpLeft, jumpRight, win, lose};

    // Rising-edge and exclusivity tally, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (outs[i] && !prev[i]) rises[i] = rises[i] + 1;
        end
        if ($countones(outs) > 1) multi = multi + 1;
        prev = outs;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        repeat (n) begin
            tick(1);
            chk(tag, outs, 6'b0);
        end
    endtask

    initial begin
        tick(2);
        chk("reset_outs", outs, 6'b0);
        reset = 1'b0;
        tick(3);
        chk("idle_after_reset", outs, 6'b0);

        // clean btnUp press: high 6 edges after first sample, held JH cycles
        base = rises[5];
        btnUp = 1'b1;
        tick(6);
        chk("up_before_latency", outs, 6'b0);
        tick(1);
        chk("up_rise", outs, O_FWD);
        tick(JH - 1);
        chk("up_last_hold", outs, O_FWD);
        tick(1);
        chk("up_end", outs, 6'b0);
        btnUp = 1'b0;
        idle_check("up_release_quiet", 12);
        chk("up_once", rises[5] - base, 1);

        // btnLeft bounce shorter than debounce, then held
        base = rises[3];
        for (int k = 0; k < 3; k++) begin
            btnLeft = 1'b1;
            tick(1);
            chk("left_bounce", outs, 6'b0);
            tick(1);
            chk("left_bounce", outs, 6'b0);
            btnLeft = 1'b0;
            tick(1);
            chk("left_bounce", outs, 6'b0);
        end
        btnLeft = 1'b1;
        tick(6);
        chk("left_before_latency", outs, 6'b0);
        tick(1);
        chk("left_rise", outs, O_LEFT);
        tick(JH - 1);
        chk("left_last_hold", outs, O_LEFT);
        tick(1);
        chk("left_end", outs, 6'b0);
        btnLeft = 1'b0;
        idle_check("left_release_quiet", 10);
        chk("left_once", rises[3] - base, 1);

        // simultaneous Right+Down -> Backward; Up lands mid-hold
        base = rises[2];
        btnRight = 1'b1;
        btnDown  = 1'b1;
        tick(4);
        btnUp = 1'b1;
        tick(2);
        chk("rd_before_latency", outs, 6'b0);
        tick(1);
        chk("rd_back_wins", outs, O_BACK);
        btnRight = 1'b0;
        btnDown  = 1'b0;
        tick(3);
        chk("rd_back_cycle4", outs, O_BACK);
        tick(1);
        chk("switch_to_fwd", outs, O_FWD);
        tick(JH - 1);
        chk("fwd_last_hold", outs, O_FWD);
        tick(1);
        chk("fwd_end", outs, 6'b0);
        btnUp = 1'b0;
        idle_check("rd_quiet", 10);
        chk("right_dropped", rises[2] - base, 0);

        // winPulse during jumpRight; Up press during win is ignored
        base = rises[5];
        btnRight = 1'b1;
        tick(6);
        chk("right_before_latency", outs, 6'b0);
        tick(1);
        chk("right_rise", outs, O_RGHT);
        btnRight = 1'b0;
        tick(2);
        winPulse = 1'b1;
        tick(1);
        winPulse = 1'b0;
        chk("win_replaces_right", outs, O_WIN);
        btnUp = 1'b1;
        tick(WH - 2);
        chk("win_hold_mid", outs, O_WIN);
        tick(1);
        chk("win_last_hold", outs, O_WIN);
        tick(1);
        chk("win_end", outs, 6'b0);
        btnUp = 1'b0;
        idle_check("win_quiet", 12);
        chk("up_ignored_in_win", rises[5] - base, 0);

        // coincident win and lose pulses
        base = rises[0];
        winPulse  = 1'b1;
        losePulse = 1'b1;
        tick(1);
        winPulse  = 1'b0;
        losePulse = 1'b0;
        chk("both_win", outs, O_WIN);
        tick(WH - 1);
        chk("both_win_last", outs, O_WIN);
        tick(1);
        chk("both_end", outs, 6'b0);
        chk("lose_never", rises[0] - base, 0);

        // lose, then reset mid-hold with btnDown held through release
        losePulse = 1'b1;
        tick(1);
        losePulse = 1'b0;
        chk("lose_rise", outs, O_LOSE);
        tick(3);
        btnDown = 1'b1;
        tick(2);
        chk("lose_mid", outs, O_LOSE);
        reset = 1'b1;
        #1;
        chk("reset_async", outs, 6'b0);
        tick(2);
        chk("reset_held", outs, 6'b0);
        reset = 1'b0;
        base = rises[4];
        tick(6);
        chk("down_before_latency", outs, 6'b0);
        tick(1);
        chk("down_rise", outs, O_BACK);
        tick(50);
        btnDown = 1'b0;
        tick(15);
        chk("down_rise_count", rises[4] - base, HELD_BACK_RISES);
        chk("final_idle", outs, 6'b0);

        chk("one_hot_outputs", multi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
